// File: rtl/pc_seq_pkg.sv
// Shared definitions for the PC sequencer: next-PC source encoding and stack sizing helper.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    PC_INC  = 2'b00,
    PC_BUS  = 2'b01,
    PC_ADDR = 2'b10,
    PC_RET  = 2'b11
  } pc_sel_e;

  function automatic int ras_count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack; push/pop/replace take effect on the next Clk edge.
// Pushing while full overwrites the oldest entry; popping while empty is a no-op.
module ras_stack
  import pc_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                              Clk,
  input  logic                              Reset,
  input  logic                              i_push,
  input  logic                              i_pop,
  input  logic [WIDTH-1:0]                  i_wdata,
  output logic [WIDTH-1:0]                  o_top,
  output logic [ras_count_width(DEPTH)-1:0] o_count,
  output logic                              o_full,
  output logic                              o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = ras_count_width(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_ptr;
  logic [CW-1:0]    r_count;
  logic [PW-1:0]    w_ptr_inc;
  logic             w_replace;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_ptr_inc = r_ptr + 1'b1;
  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_count   = r_count;
  assign o_top     = r_mem[r_ptr];

  // Push+pop on a non-empty stack rewrites the top in place; on an empty stack it is a plain push.
  assign w_replace = i_push & i_pop & ~o_empty;
  assign w_do_push = i_push & ~w_replace;
  assign w_do_pop  = i_pop & ~i_push & ~o_empty;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (w_do_push) begin
      r_ptr <= w_ptr_inc;
      if (!o_full) r_count <= r_count + 1'b1;
    end else if (w_do_pop) begin
      r_ptr   <= r_ptr - 1'b1;
      r_count <= r_count - 1'b1;
    end
  end

  // Entry contents are don't-care while the count is zero, so storage carries no reset.
  always_ff @(posedge Clk) begin
    if (w_do_push) r_mem[w_ptr_inc] <= i_wdata;
    else if (w_replace) r_mem[r_ptr] <= i_wdata;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with next-PC source select, call/return stack and sticky stack error flags.
// All loads appear one Clk after the edge; Next_PC and stack status are combinational.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               RAS_DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_PC  = '0
) (
  input  logic                                  Clk,
  input  logic                                  Reset,
  input  logic                                  LD_PC,
  input  logic [1:0]                            PC_Sel,
  input  logic [WIDTH-1:0]                      Bus_In,
  input  logic [WIDTH-1:0]                      Addr_In,
  input  logic                                  Push,
  input  logic                                  Clear_Flags,
  output logic [WIDTH-1:0]                      PC,
  output logic [WIDTH-1:0]                      Next_PC,
  output logic [ras_count_width(RAS_DEPTH)-1:0] RAS_Count,
  output logic                                  RAS_Empty,
  output logic                                  RAS_Full,
  output logic                                  RAS_Overflow,
  output logic                                  RAS_Underflow
);

  pc_sel_e          w_sel;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] w_next_pc;
  logic [WIDTH-1:0] w_pc_d;
  logic [WIDTH-1:0] w_top;
  logic             w_push;
  logic             w_pop;
  logic             w_ovf_set;
  logic             w_udf_set;
  logic             r_ovf;
  logic             r_udf;

  assign w_sel     = pc_sel_e'(PC_Sel);
  assign w_next_pc = r_pc + 1'b1;
  assign w_push    = LD_PC & Push;
  assign w_pop     = LD_PC & (w_sel == PC_RET);
  assign w_ovf_set = w_push & ~w_pop & RAS_Full;
  assign w_udf_set = w_pop & RAS_Empty;

  always_comb begin
    w_pc_d = w_next_pc;
    case (w_sel)
      PC_INC:  w_pc_d = w_next_pc;
      PC_BUS:  w_pc_d = Bus_In;
      PC_ADDR: w_pc_d = Addr_In;
      PC_RET:  w_pc_d = RAS_Empty ? w_next_pc : w_top;
      default: w_pc_d = w_next_pc;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_pc  <= RESET_PC;
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else if (LD_PC) begin
      r_pc  <= w_pc_d;
      // A flag-setting event wins over a clear in the same cycle.
      r_ovf <= (r_ovf & ~Clear_Flags) | w_ovf_set;
      r_udf <= (r_udf & ~Clear_Flags) | w_udf_set;
    end
  end

  ras_stack #(
    .WIDTH(WIDTH),
    .DEPTH(RAS_DEPTH)
  ) u_ras (
    .Clk    (Clk),
    .Reset  (Reset),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_wdata(w_next_pc),
    .o_top  (w_top),
    .o_count(RAS_Count),
    .o_full (RAS_Full),
    .o_empty(RAS_Empty)
  );

  assign PC            = r_pc;
  assign Next_PC       = w_next_pc;
  assign RAS_Overflow  = r_ovf;
  assign RAS_Underflow = r_udf;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: vector table through a scoreboard plus reset corner cases.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        LD_PC;
  logic [1:0]  PC_Sel;
  logic [15:0] Bus_In;
  logic [15:0] Addr_In;
  logic        Push;
  logic        Clear_Flags;
  logic [15:0] PC;
  logic [15:0] Next_PC;
  logic [2:0]  RAS_Count;
  logic        RAS_Empty;
  logic        RAS_Full;
  logic        RAS_Overflow;
  logic        RAS_Underflow;

  pc_sequencer #(.WIDTH(16), .RAS_DEPTH(4), .RESET_PC(16'h0000)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .LD_PC        (LD_PC),
    .PC_Sel       (PC_Sel),
    .Bus_In       (Bus_In),
    .Addr_In      (Addr_In),
    .Push         (Push),
    .Clear_Flags  (Clear_Flags),
    .PC           (PC),
    .Next_PC      (Next_PC),
    .RAS_Count    (RAS_Count),
    .RAS_Empty    (RAS_Empty),
    .RAS_Full     (RAS_Full),
    .RAS_Overflow (RAS_Overflow),
    .RAS_Underflow(RAS_Underflow)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        ld;
    logic [1:0]  sel;
    logic [15:0] bus;
    logic [15:0] addr;
    logic        push;
    logic        clr;
    logic [15:0] e_pc;
    logic [2:0]  e_cnt;
    logic        e_ovf;
    logic        e_udf;
  } vec_t;

  typedef struct {
    logic [15:0] pc;
    logic [2:0]  cnt;
    logic        ovf;
    logic        udf;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(input logic ld, input pc_sel_e sel, input logic [15:0] bus,
                              input logic [15:0] addr, input logic push, input logic clr,
                              input logic [15:0] e_pc, input logic [2:0] e_cnt,
                              input logic e_ovf, input logic e_udf);
    vec_t v;
    v.ld = ld; v.sel = sel; v.bus = bus; v.addr = addr; v.push = push; v.clr = clr;
    v.e_pc = e_pc; v.e_cnt = e_cnt; v.e_ovf = e_ovf; v.e_udf = e_udf;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic observe(input string tag);
    exp_t        e;
    logic [15:0] e_npc;
    if (sb.size() == 0) begin
      chk({tag, " scoreboard_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    e_npc = e.pc + 16'h0001;
    chk({tag, " PC"}, 32'(PC), 32'(e.pc));
    chk({tag, " Next_PC"}, 32'(Next_PC), 32'(e_npc));
    chk({tag, " RAS_Count"}, 32'(RAS_Count), 32'(e.cnt));
    chk({tag, " RAS_Empty"}, 32'(RAS_Empty), 32'(e.cnt == 3'd0));
    chk({tag, " RAS_Full"}, 32'(RAS_Full), 32'(e.cnt == 3'd4));
    chk({tag, " RAS_Overflow"}, 32'(RAS_Overflow), 32'(e.ovf));
    chk({tag, " RAS_Underflow"}, 32'(RAS_Underflow), 32'(e.udf));
  endtask

  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    @(negedge Clk);
    LD_PC = v.ld; PC_Sel = v.sel; Bus_In = v.bus; Addr_In = v.addr;
    Push = v.push; Clear_Flags = v.clr;
    e.pc = v.e_pc; e.cnt = v.e_cnt; e.ovf = v.e_ovf; e.udf = v.e_udf;
    sb.push_back(e);
    @(posedge Clk);
    #1;
    observe(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; LD_PC = 1'b0; PC_Sel = 2'b00; Bus_In = '0; Addr_In = '0;
    Push = 1'b0; Clear_Flags = 1'b0;

    //           ld  sel      bus       addr      psh  clr  pc        cnt ovf udf
    tbl.push_back(mk(1, PC_INC,  16'h0000, 16'h0000, 0, 0, 16'h0001, 0, 0, 0));
    tbl.push_back(mk(1, PC_INC,  16'h0000, 16'h0000, 0, 0, 16'h0002, 0, 0, 0));
    tbl.push_back(mk(1, PC_INC,  16'h0000, 16'h0000, 0, 0, 16'h0003, 0, 0, 0));
    tbl.push_back(mk(1, PC_BUS,  16'h3000, 16'h0000, 0, 0, 16'h3000, 0, 0, 0));
    tbl.push_back(mk(1, PC_ADDR, 16'h0000, 16'h3100, 1, 0, 16'h3100, 1, 0, 0));
    tbl.push_back(mk(1, PC_RET,  16'h0000, 16'h0000, 0, 0, 16'h3001, 0, 0, 0));
    tbl.push_back(mk(1, PC_BUS,  16'h0010, 16'h0000, 0, 0, 16'h0010, 0, 0, 0));
    tbl.push_back(mk(1, PC_BUS,  16'h0011, 16'h0000, 1, 0, 16'h0011, 1, 0, 0));
    tbl.push_back(mk(1, PC_BUS,  16'h0012, 16'h0000, 1, 0, 16'h0012, 2, 0, 0));
    tbl.push_back(mk(1, PC_BUS,  16'h0013, 16'h0000, 1, 0, 16'h0013, 3, 0, 0));
    tbl.push_back(mk(1, PC_BUS,  16'h0014, 16'h0000, 1, 0, 16'h0014, 4, 0, 0));
    tbl.push_back(mk(1, PC_BUS,  16'h0015, 16'h0000, 1, 0, 16'h0015, 4, 1, 0));
    tbl.push_back(mk(1, PC_RET,  16'h0000, 16'h0000, 0, 0, 16'h0015, 3, 1, 0));
    tbl.push_back(mk(1, PC_RET,  16'h0000, 16'h0000, 0, 0, 16'h0014, 2, 1, 0));
    tbl.push_back(mk(1, PC_RET,  16'h0000, 16'h0000, 0, 0, 16'h0013, 1, 1, 0));
    tbl.push_back(mk(1, PC_RET,  16'h0000, 16'h0000, 0, 0, 16'h0012, 0, 1, 0));
    tbl.push_back(mk(1, PC_INC,  16'h0000, 16'h0000, 0, 1, 16'h0013, 0, 0, 0));
    tbl.push_back(mk(1, PC_BUS,  16'h00FF, 16'h0000, 0, 0, 16'h00FF, 0, 0, 0));
    tbl.push_back(mk(1, PC_RET,  16'h0000, 16'h0000, 0, 0, 16'h0100, 0, 0, 1));
    tbl.push_back(mk(1, PC_INC,  16'h0000, 16'h0000, 0, 1, 16'h0101, 0, 0, 0));
    tbl.push_back(mk(1, PC_BUS,  16'h2004, 16'h0000, 0, 0, 16'h2004, 0, 0, 0));
    tbl.push_back(mk(1, PC_BUS,  16'h4000, 16'h0000, 1, 0, 16'h4000, 1, 0, 0));
    tbl.push_back(mk(1, PC_RET,  16'h0000, 16'h0000, 1, 0, 16'h2005, 1, 0, 0));
    tbl.push_back(mk(0, PC_RET,  16'h1234, 16'h5678, 1, 0, 16'h2005, 1, 0, 0));
    tbl.push_back(mk(0, PC_BUS,  16'h1234, 16'h5678, 1, 0, 16'h2005, 1, 0, 0));
    tbl.push_back(mk(1, PC_RET,  16'h0000, 16'h0000, 0, 0, 16'h4001, 0, 0, 0));
    tbl.push_back(mk(1, PC_BUS,  16'h0500, 16'h0000, 0, 0, 16'h0500, 0, 0, 0));
    tbl.push_back(mk(1, PC_RET,  16'h0000, 16'h0000, 1, 0, 16'h0501, 1, 0, 1));
    tbl.push_back(mk(1, PC_RET,  16'h0000, 16'h0000, 0, 0, 16'h0501, 0, 0, 1));
    tbl.push_back(mk(1, PC_RET,  16'h0000, 16'h0000, 0, 1, 16'h0502, 0, 0, 1));
    tbl.push_back(mk(1, PC_INC,  16'h0000, 16'h0000, 0, 1, 16'h0503, 0, 0, 0));
    tbl.push_back(mk(1, PC_INC,  16'h0000, 16'h0000, 1, 0, 16'h0504, 1, 0, 0));
    tbl.push_back(mk(1, PC_RET,  16'h0000, 16'h0000, 0, 0, 16'h0504, 0, 0, 0));
    tbl.push_back(mk(1, PC_BUS,  16'hFFFF, 16'h0000, 0, 0, 16'hFFFF, 0, 0, 0));
    tbl.push_back(mk(1, PC_INC,  16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(1, PC_INC,  16'h0000, 16'h0000, 1, 0, 16'h0001, 1, 0, 0));

    #12;
    chk("reset PC", 32'(PC), 32'h0000);
    chk("reset Next_PC", 32'(Next_PC), 32'h0001);
    chk("reset RAS_Count", 32'(RAS_Count), 32'd0);
    chk("reset RAS_Empty", 32'(RAS_Empty), 32'd1);
    chk("reset RAS_Overflow", 32'(RAS_Overflow), 32'd0);
    chk("reset RAS_Underflow", 32'(RAS_Underflow), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // Reset raised between edges while a push is pending: must act at once and leave nothing behind.
    @(negedge Clk);
    LD_PC = 1'b1; PC_Sel = PC_INC; Push = 1'b1; Clear_Flags = 1'b0;
    #2;
    Reset = 1'b1;
    #1;
    chk("midreset PC", 32'(PC), 32'h0000);
    chk("midreset RAS_Count", 32'(RAS_Count), 32'd0);
    chk("midreset RAS_Empty", 32'(RAS_Empty), 32'd1);
    @(posedge Clk);
    #1;
    chk("held reset PC", 32'(PC), 32'h0000);
    chk("held reset RAS_Count", 32'(RAS_Count), 32'd0);
    @(negedge Clk);
    Reset = 1'b0; LD_PC = 1'b0; Push = 1'b0;
    apply(mk(0, PC_INC, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 0), "post_reset idle");
    apply(mk(1, PC_RET, 16'h0000, 16'h0000, 0, 0, 16'h0001, 0, 0, 1), "post_reset ret");

    if (sb.size() != 0) chk("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16: width of the PC and of all address ports.
REQ-002 SHALL have parameter RAS_DEPTH, default 4: number of return-address stack entries, at least 2 and a power of two.
REQ-003 SHALL have parameter RESET_PC, default 16'h0000 (WIDTH bits): PC value after reset.
REQ-004 SHALL have port Clk, input, 1: clock; all state updates on its rising edge.
REQ-005 SHALL have port Reset, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port LD_PC, input, 1: load enable from the control unit; no state changes when it is 0.
REQ-007 SHALL have port PC_Sel, input, 2: next-PC source; INC=00, BUS=01, ADDR=10, RET=11.
REQ-008 SHALL have port Bus_In, input, WIDTH: data-bus value used for the BUS source.
REQ-009 SHALL have port Addr_In, input, WIDTH: address-adder result used for the ADDR source.
REQ-010 SHALL have port Push, input, 1: call indication; saves the return address to the stack.
REQ-011 SHALL have port Clear_Flags, input, 1: clears the sticky error flags.
REQ-012 SHALL have port PC, output, WIDTH: current program counter.
REQ-013 SHALL have port Next_PC, output, WIDTH: PC+1 modulo 2^WIDTH, combinational from PC.
REQ-014 SHALL have port RAS_Count, output, $clog2(RAS_DEPTH)+1: number of valid stack entries.
REQ-015 SHALL have ports RAS_Empty and RAS_Full, output, 1 each: RAS_Count==0 and RAS_Count==RAS_DEPTH respectively.
REQ-016 SHALL have ports RAS_Overflow and RAS_Underflow, output, 1 each: sticky error flags.

Function
REQ-017 SHALL, on a rising Clk with LD_PC=1, load PC with: INC gives Next_PC; BUS gives Bus_In; ADDR gives Addr_In; RET gives the stack top, or Next_PC if the stack is empty.
REQ-018 SHALL hold PC, the stack contents and the flags unchanged when LD_PC=0, and SHALL ignore Push and RET in that cycle.
REQ-019 SHALL, for a push (LD_PC=1, Push=1, PC_Sel other than RET), write Next_PC of the current cycle as the new top and increment RAS_Count, saturating at RAS_DEPTH.
REQ-020 SHALL, for a push while RAS_Full, overwrite the oldest entry (circular buffer), keep RAS_Count=RAS_DEPTH and set RAS_Overflow.
REQ-021 SHALL, for a pop (LD_PC=1, PC_Sel=RET, Push=0) with the stack non-empty, remove the top entry and decrement RAS_Count.
REQ-022 SHALL, for a pop with the stack empty, leave RAS_Count at 0 and set RAS_Underflow.
REQ-023 SHALL, when Push=1 and PC_Sel=RET together, load PC with the old top and replace the top with Next_PC, leaving RAS_Count unchanged.
REQ-024 SHALL, for a simultaneous push and pop on an empty stack, take Next_PC as the PC value, set RAS_Underflow, write one entry and set RAS_Count=1.
REQ-025 SHALL treat a push at INC source as legal and perform it.
REQ-026 SHALL clear both sticky flags in the cycle after Clear_Flags=1; a flag-setting event in that same cycle takes priority and leaves the flag at 1.
REQ-027 SHALL wrap PC arithmetic modulo 2^WIDTH, so PC=all-ones with INC gives 0.
REQ-028 SHALL make every load and stack update visible on the outputs in the cycle after the edge (latency 1); Next_PC and the status outputs are combinational from the registers.

Reset
REQ-029 SHALL, on Reset=1, immediately set PC=RESET_PC, RAS_Count=0, RAS_Overflow=0 and RAS_Underflow=0, regardless of Clk.
REQ-030 SHALL treat stack entry contents as don't-care after reset; no output depends on them while RAS_Count=0.
REQ-031 SHALL abandon any operation in progress on a Reset asserted mid-cycle, with no partial stack update surviving.

Structure
REQ-032 SHALL place the PC_Sel encoding (enum pc_sel_e: PC_INC, PC_BUS, PC_ADDR, PC_RET) in shared package pc_seq_pkg.
REQ-033 SHALL implement the return-address stack as sub-module ras_stack, parametrised by WIDTH and RAS_DEPTH, with push/pop/top/count/full/empty ports and a circular top pointer.
REQ-034 SHALL keep PC selection and flag logic in pc_sequencer.

Verification
REQ-035 SHALL test reset then 3 cycles of LD_PC=1 at INC: PC shows 0000 -> 0001 -> 0002 -> 0003, and Next_PC=0004.
REQ-036 SHALL test PC=3000 with a Push at ADDR, Addr_In=3100: PC=3100, top=3001, RAS_Count=1; then RET gives PC=3001 and RAS_Count=0.
REQ-037 SHALL test 5 pushes with RAS_DEPTH=4, return addresses 0011..0015: RAS_Overflow=1, RAS_Count=4; 4 RETs give PC 0015, 0014, 0013, 0012.
REQ-038 SHALL test RET on an empty stack at PC=00FF: PC=0100, RAS_Underflow=1; then Clear_Flags=1 gives RAS_Underflow=0.
REQ-039 SHALL test Push and RET together with top=2005 and PC=4000: PC=2005, top=4001, count unchanged; then LD_PC=0 for 2 cycles: no change.
REQ-040 SHALL test PC=FFFF with INC: PC becomes 0000; Reset asserted between edges forces PC=RESET_PC and RAS_Count=0 immediately.
